// File: rtl/divider_n_bit_seq_pkg.sv
// Shared ALU package: operation codes, default widths and the sequential
// divider's state encoding and counter sizing.
package divider_n_bit_seq_pkg;

    localparam int ALU_WIDTH_DEFAULT = 8;
    localparam int DIV_N_DEFAULT     = ALU_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Counter must be able to hold N itself.
    function automatic int div_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_n_bit_seq_if.sv
// Request/result bundle of the sequential divider; the requester drives
// start and operands, the divider drives status and results.
interface divider_n_bit_seq_if
    import divider_n_bit_seq_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
);
    logic         start;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         busy;
    logic         done;
    logic [N-1:0] out;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, in_a, in_b,
        input  busy, done, out, remainder, div_by_zero
    );

    modport slave (
        input  start, in_a, in_b,
        output busy, done, out, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_n_bit_seq_addsub.sv
// W-bit adder/subtractor from the ALU library; subtraction is a + ~b + 1.
module divider_n_bit_seq_addsub
    import divider_n_bit_seq_pkg::*;
#(
    parameter int W = ALU_WIDTH_DEFAULT + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] result
);
    logic         sub;
    logic [W-1:0] b_eff;

    always_comb begin
        sub    = (op == ALU_SUB);
        b_eff  = b ^ {W{sub}};
        result = a + b_eff + W'(sub);
    end
endmodule

// File: rtl/divider_n_bit_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first,
// results registered on the final iteration and held until the next one.
module divider_n_bit_seq
    import divider_n_bit_seq_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    divider_n_bit_seq_if.slave bus
);
    localparam int CW = div_cnt_w(N);

    div_state_e   state, state_next;
    logic [CW-1:0] cnt;
    logic [N-1:0]  divisor;
    logic [N-1:0]  work_q;     // dividend bits shift out the top, quotient bits in the bottom
    logic [N:0]    part_rem;
    logic [N-1:0]  out_r, rem_r;
    logic          dbz_r;

    logic [N:0]    shifted, diff, rem_next;
    logic          q_bit, last_iter;
    logic          rem_msb_unused;

    // Kept remainder is always below the divisor, so its top bit never feeds the shift.
    assign rem_msb_unused = part_rem[N];
    assign shifted        = {part_rem[N-1:0], work_q[N-1]};
    assign last_iter      = (cnt == CW'(N - 1));

    divider_n_bit_seq_addsub #(.W(N + 1)) u_trial_sub (
        .a      (shifted),
        .b      ({1'b0, divisor}),
        .op     (ALU_SUB),
        .result (diff)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        q_bit    = ~diff[N];
        rem_next = shifted;
        if (q_bit) begin
            rem_next = diff;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and an async reset in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            divisor  <= '0;
            work_q   <= '0;
            part_rem <= '0;
            out_r    <= '0;
            rem_r    <= '0;
            dbz_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        divisor  <= bus.in_b;
                        work_q   <= bus.in_a;
                        part_rem <= '0;
                        cnt      <= '0;
                    end
                end
                ST_RUN: begin
                    part_rem <= rem_next;
                    work_q   <= {work_q[N-2:0], q_bit};
                    cnt      <= cnt + CW'(1);
                    // Visible results only change on the final iteration.
                    if (last_iter) begin
                        out_r <= {work_q[N-2:0], q_bit};
                        rem_r <= rem_next[N-1:0];
                        dbz_r <= (divisor == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == ST_RUN);
    assign bus.done        = (state == ST_DONE);
    assign bus.out         = out_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_divider_n_bit_seq.sv
// Self-checking bench for divider_n_bit_seq: directed table, multi-cycle
// corner sequences and a random sweep on N=8 and N=7 instances.
module tb_divider_n_bit_seq;
    localparam int N8 = 8;
    localparam int N7 = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    divider_n_bit_seq_if #(.N(N8)) bus8 ();
    divider_n_bit_seq_if #(.N(N7)) bus7 ();

    divider_n_bit_seq #(.N(N8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    divider_n_bit_seq #(.N(N7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic dbz, input int unsigned q, input int unsigned r);
        return {7'd0, dbz, q[11:0], r[11:0]};
    endfunction

    function automatic logic [31:0] ref_model(input int n, input int unsigned a, input int unsigned b);
        if (b == 0) return pack(1'b1, (1 << n) - 1, a);
        return pack(1'b0, a / b, a % b);
    endfunction

    task automatic run_div8(input logic [7:0] a, input logic [7:0] b,
                            output logic [31:0] res, output int lat);
        @(negedge clk);
        bus8.start = 1'b1; bus8.in_a = a; bus8.in_b = b;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        lat = 1;
        while (bus8.done !== 1'b1 && lat < 4 * N8) begin
            @(negedge clk);
            lat++;
        end
        res = pack(bus8.div_by_zero, bus8.out, bus8.remainder);
    endtask

    task automatic run_div7(input logic [6:0] a, input logic [6:0] b,
                            output logic [31:0] res, output int lat);
        @(negedge clk);
        bus7.start = 1'b1; bus7.in_a = a; bus7.in_b = b;
        @(posedge clk);
        @(negedge clk);
        bus7.start = 1'b0;
        lat = 1;
        while (bus7.done !== 1'b1 && lat < 4 * N7) begin
            @(negedge clk);
            lat++;
        end
        res = pack(bus7.div_by_zero, bus7.out, bus7.remainder);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res, prev;
        int          lat, busy_low, changes, pulses;
        logic [7:0]  a8, b8;
        logic [6:0]  a7, b7;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2, 1'b0};
        vecs[1]  = '{8'd5,   8'd0,   8'hFF,  8'd5, 1'b1};
        vecs[2]  = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0};
        vecs[3]  = '{8'd3,   8'd200, 8'd0,   8'd3, 1'b0};
        vecs[4]  = '{8'd200, 8'd3,   8'd66,  8'd2, 1'b0};
        vecs[5]  = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0};
        vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0, 1'b0};
        vecs[7]  = '{8'd0,   8'd0,   8'hFF,  8'd0, 1'b1};
        vecs[8]  = '{8'd128, 8'd16,  8'd8,   8'd0, 1'b0};
        vecs[9]  = '{8'd254, 8'd127, 8'd2,   8'd0, 1'b0};
        vecs[10] = '{8'd77,  8'd10,  8'd7,   8'd7, 1'b0};
        vecs[11] = '{8'd1,   8'd2,   8'd0,   8'd1, 1'b0};

        bus8.start = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
        bus7.start = 1'b0; bus7.in_a = '0; bus7.in_b = '0;

        #2;
        check("reset_state", {13'd0, bus8.busy, bus8.done, bus8.div_by_zero, bus8.out, bus8.remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; the first start after reset release must be accepted.
        for (int i = 0; i < 12; i++) begin
            run_div8(vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, pack(vecs[i].dbz, vecs[i].q, vecs[i].r));
            check($sformatf("vec%0d_latency", i), lat, N8 + 1);
        end
        @(negedge clk);
        check("done_one_cycle", {30'd0, bus8.busy, bus8.done}, 32'd0);

        // Start pulsed mid-RUN with new operands must be ignored.
        bus8.start = 1'b1; bus8.in_a = 8'd100; bus8.in_b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        prev = pack(bus8.div_by_zero, bus8.out, bus8.remainder);
        lat = 1; busy_low = 0; changes = 0;
        while (bus8.done !== 1'b1 && lat < 4 * N8) begin
            if (bus8.busy !== 1'b1) busy_low++;
            if (pack(bus8.div_by_zero, bus8.out, bus8.remainder) !== prev) changes++;
            if (lat == 3) begin
                bus8.start = 1'b1; bus8.in_a = 8'd50; bus8.in_b = 8'd3;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("intrude_busy_low", busy_low, 0);
        check("intrude_output_hold", changes, 0);
        check("intrude_latency", lat, N8 + 1);
        check("intrude_result", pack(bus8.div_by_zero, bus8.out, bus8.remainder), pack(1'b0, 14, 2));
        pulses = 0;
        for (int k = 0; k < N8 + 4; k++) begin
            @(negedge clk);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) pulses++;
        end
        check("intrude_not_queued", pulses, 0);

        // Asynchronous reset in RUN cycle 4 aborts the operation.
        bus8.start = 1'b1; bus8.in_a = 8'd200; bus8.in_b = 8'd3;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        for (int k = 1; k < 4; k++) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_async_clear", {13'd0, bus8.busy, bus8.done, bus8.div_by_zero, bus8.out, bus8.remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 2 * N8; k++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) pulses++;
        end
        check("rst_no_done", pulses, 0);
        run_div8(8'd100, 8'd7, res, lat);
        check("post_rst_result", res, pack(1'b0, 14, 2));
        check("post_rst_latency", lat, N8 + 1);

        // Start held high from a DONE cycle: one result every N+2 cycles.
        bus8.start = 1'b1; bus8.in_a = 8'd100; bus8.in_b = 8'd7;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (bus8.done !== 1'b1 && lat < 4 * N8);
            check($sformatf("b2b%0d_spacing", k), lat, N8 + 2);
            res = pack(bus8.div_by_zero, bus8.out, bus8.remainder);
            case (k)
                0: begin
                    check("b2b0_result", res, pack(1'b0, 14, 2));
                    bus8.in_a = 8'd200; bus8.in_b = 8'd9;
                end
                1: begin
                    check("b2b1_result", res, pack(1'b0, 22, 2));
                    bus8.in_a = 8'd9; bus8.in_b = 8'd0;
                end
                default: begin
                    check("b2b2_result", res, pack(1'b1, 255, 9));
                    bus8.start = 1'b0;
                end
            endcase
        end
        @(negedge clk);
        @(negedge clk);
        check("b2b_stopped", {30'd0, bus8.busy, bus8.done}, 32'd0);

        // Random sweeps against the reference model, including forced zero divisors.
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_div8(a8, b8, res, lat);
            check("sweep8_result", res, ref_model(N8, a8, b8));
            check("sweep8_latency", lat, N8 + 1);
        end
        for (int i = 0; i < 1000; i++) begin
            a7 = 7'($urandom_range(0, 127));
            b7 = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            run_div7(a7, b7, res, lat);
            check("sweep7_result", res, ref_model(N7, a7, b7));
            check("sweep7_latency", lat, N7 + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/divider_n_bit_seq.md
DIVIDER_N_BIT_SEQ -- requirements
Module: DIVIDER_N_BIT_SEQ

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 in_a  input  N  unsigned dividend; captured on accepted start.
REQ-006 in_b  input  N  unsigned divisor; captured on accepted start.
REQ-007 busy  output  1  high while a division is in progress (RUN).
REQ-008 done  output  1  one-cycle pulse; results valid that cycle and held after.
REQ-009 out  output  N  quotient.
REQ-010 remainder  output  N  remainder.
REQ-011 div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE after N iterations; DONE -> IDLE unconditionally after one cycle.
REQ-013 Accepted start in IDLE: operands are registered, the iteration counter is cleared, and busy is raised the next cycle.
REQ-014 RUN: restoring division, one quotient bit per cycle, MSB first; partial remainder is N+1 bits wide; shift-left, trial subtract of the divisor, keep the result if non-negative and set the quotient bit to 1, else restore and set it to 0.
REQ-015 Latency: done asserts exactly N+1 cycles after the cycle in which start was sampled high.
REQ-016 Results satisfy in_a == out*in_b + remainder and remainder < in_b for in_b != 0.
REQ-017 in_b == 0: the block takes the same N+1 cycle path; done=1, div_by_zero=1, out = all ones, remainder = in_a.
REQ-018 out, remainder and div_by_zero hold their values from done until the next accepted start completes; they do not change during RUN.
REQ-019 start while busy or in DONE is ignored; operand changes after capture have no effect.
REQ-020 start high in the same cycle done pulses is ignored; a new start is accepted only in IDLE, the cycle after DONE at earliest.
REQ-021 Back-to-back: start held high continuously produces one result every N+2 cycles.

Reset
REQ-022 rst forces IDLE immediately, regardless of clock; busy=0, done=0, out=0, remainder=0, div_by_zero=0, counter=0.
REQ-023 rst asserted mid-RUN aborts the operation; no done pulse is produced for it.
REQ-024 After rst deasserts, the first rising edge with start=1 is accepted.

Structure
REQ-025 FSM state encodings and the counter width ($clog2(N+1)) are defined in a shared ALU package/include alongside the existing ALU constants.
REQ-026 One sub-module: the combinational trial subtract is the existing N-bit adder/subtractor block (N+1-bit instance); the FSM and registers are in the top module.
REQ-027 Counter and state registers only; no combinational path from start or in_a/in_b to any output.

Verification
REQ-028 N=8, in_a=100, in_b=7, start pulse -> done at cycle +9; out=14, remainder=2, div_by_zero=0.
REQ-029 in_a=5, in_b=0 -> done at +9; div_by_zero=1, out=8'hFF, remainder=5.
REQ-030 in_a=255, in_b=1 -> out=255, rem=0; in_a=3, in_b=200 -> out=0, rem=3.
REQ-031 start pulsed at RUN cycle 3 with different operands -> ignored; result reflects the first operands; busy stays high throughout.
REQ-032 rst asserted at RUN cycle 4 -> busy=0 and all outputs 0 asynchronously; no done pulse follows; a later start with 100/7 yields 14 r2.
REQ-033 start held high for 3 operations, plus a randomized 1000-pair sweep (N=7 and N=8) -> done spacing N+2; every result matches the reference model including divide-by-zero rules.
